// File: rtl/pulse_stretch_mc_if.sv
// rtl/pulse_stretch_mc_if.sv - per-channel event/level bundle for the pulse stretcher
interface pulse_stretch_mc_if #(
    parameter int CH = 4
) ();
    logic [CH-1:0] pulse_f;
    logic [CH-1:0] ovf_clr;
    logic [CH-1:0] level_out;
    logic [CH-1:0] busy;
    logic [CH-1:0] overflow;

    modport master (
        output pulse_f,
        output ovf_clr,
        input  level_out,
        input  busy,
        input  overflow
    );

    modport slave (
        input  pulse_f,
        input  ovf_clr,
        output level_out,
        output busy,
        output overflow
    );
endinterface

// File: rtl/pulse_stretch_mc.sv
// rtl/pulse_stretch_mc.sv - multi-channel pulse stretcher for fast-to-slow single-bit crossings
module pulse_stretch_mc #(
    parameter int CH      = 4,
    parameter int STRETCH = 3,
    parameter int GAP     = 3,
    parameter int PEND_W  = 2
) (
    input  logic              clk_f,
    input  logic              rst_n,
    pulse_stretch_mc_if.slave io
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HIGH = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    localparam int MAX_LEN = (STRETCH > GAP) ? STRETCH : GAP;
    localparam int CNT_W   = $clog2(MAX_LEN + 1);

    localparam logic [CNT_W-1:0]  CNT_HIGH = CNT_W'(STRETCH - 1);
    localparam logic [CNT_W-1:0]  CNT_GAP  = CNT_W'(GAP - 1);
    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    logic [CH-1:0] level_vec;
    logic [CH-1:0] busy_vec;
    logic [CH-1:0] ovf_vec;

    for (genvar g = 0; g < CH; g++) begin : g_ch
        logic [1:0]        state_q, state_d;
        logic [CNT_W-1:0]  cnt_q, cnt_d;
        logic [PEND_W-1:0] pend_q, pend_d;
        logic              level_q, level_d;
        logic              ovf_q, ovf_d;
        logic              pulse;
        logic              pend_nz;
        logic              ev_inc;
        logic              ev_dec;
        logic              ovf_set;

        assign pulse   = io.pulse_f[g];
        assign pend_nz = (pend_q != '0);

        // A start from IDLE or at gap end prefers a queued event; a pulse in the
        // same cycle then replaces it in the queue, leaving the count unchanged.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            ev_inc  = 1'b0;
            ev_dec  = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (pulse || pend_nz) begin
                        state_d = ST_HIGH;
                        cnt_d   = CNT_HIGH;
                        ev_dec  = pend_nz;
                        ev_inc  = pulse && pend_nz;
                    end
                end
                ST_HIGH: begin
                    ev_inc = pulse;
                    if (cnt_q == '0) begin
                        state_d = ST_GAP;
                        cnt_d   = CNT_GAP;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                ST_GAP: begin
                    if (cnt_q != '0) begin
                        cnt_d  = cnt_q - 1'b1;
                        ev_inc = pulse;
                    end else if (pulse || pend_nz) begin
                        state_d = ST_HIGH;
                        cnt_d   = CNT_HIGH;
                        ev_dec  = pend_nz;
                        ev_inc  = pulse && pend_nz;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        always_comb begin
            pend_d  = pend_q;
            ovf_set = 1'b0;
            if (ev_inc && !ev_dec) begin
                if (pend_q == PEND_MAX) begin
                    ovf_set = 1'b1;
                end else begin
                    pend_d = pend_q + 1'b1;
                end
            end else if (ev_dec && !ev_inc) begin
                pend_d = pend_q - 1'b1;
            end
            // Set beats clear so a drop in the clearing cycle is never hidden.
            if (ovf_set) begin
                ovf_d = 1'b1;
            end else if (io.ovf_clr[g]) begin
                ovf_d = 1'b0;
            end else begin
                ovf_d = ovf_q;
            end
            level_d = (state_d == ST_HIGH);
        end

        always_ff @(posedge clk_f or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
                pend_q  <= '0;
                level_q <= 1'b0;
                ovf_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                pend_q  <= pend_d;
                level_q <= level_d;
                ovf_q   <= ovf_d;
            end
        end

        assign level_vec[g] = level_q;
        assign busy_vec[g]  = (state_q != ST_IDLE) || pend_nz;
        assign ovf_vec[g]   = ovf_q;
    end

    assign io.level_out = level_vec;
    assign io.busy      = busy_vec;
    assign io.overflow  = ovf_vec;
endmodule

// File: tb/tb_pulse_stretch_mc.sv
// tb/tb_pulse_stretch_mc.sv - directed scoreboard bench for pulse_stretch_mc
module tb_pulse_stretch_mc;
    localparam int CH     = 4;
    localparam int PERIOD = 6;

    typedef struct {
        int          cyc;
        logic [11:0] exp;
        string       tag;
    } exp_t;

    logic clk_f;
    logic rst_n;
    int   edge_n;
    int   tests;
    int   fails;
    exp_t sb[$];

    pulse_stretch_mc_if #(.CH(CH)) io ();

    pulse_stretch_mc #(
        .CH(CH), .STRETCH(3), .GAP(3), .PEND_W(2)
    ) dut (
        .clk_f (clk_f),
        .rst_n (rst_n),
        .io    (io)
    );

    initial clk_f = 1'b0;
    always #5 clk_f = ~clk_f;

    function automatic logic [11:0] outs();
        return {io.level_out, io.busy, io.overflow};
    endfunction

    task automatic push(input int cyc, input logic [3:0] lvl, input logic [3:0] bsy,
                        input logic [3:0] ovf, input string tag);
        exp_t e;
        e.cyc = cyc;
        e.exp = {lvl, bsy, ovf};
        e.tag = tag;
        sb.push_back(e);
    endtask

    // Expected outputs for nout back-to-back stretched pulses starting at edge e0.
    task automatic push_train(input string tag, input logic [3:0] mask, input int e0,
                              input int nout, input int ovf_from, input int ovf_to);
        for (int c = e0; c <= e0 + PERIOD * nout + 2; c++) begin
            int off;
            off = c - e0;
            push(c,
                 ((off < PERIOD * nout) && ((off % PERIOD) < 3)) ? mask : 4'b0,
                 (off < PERIOD * nout) ? mask : 4'b0,
                 ((c >= ovf_from) && (c <= ovf_to)) ? mask : 4'b0,
                 tag);
        end
    endtask

    task automatic step();
        exp_t        e;
        logic [11:0] obs;
        @(posedge clk_f);
        edge_n++;
        @(negedge clk_f);
        while (sb.size() > 0 && sb[0].cyc <= edge_n) begin
            e   = sb.pop_front();
            obs = outs();
            tests++;
            assert (obs === e.exp && e.cyc == edge_n) else begin
                fails++;
                $error("FAIL %s edge %0d: observed lvl/busy/ovf %h expected %h", e.tag, e.cyc, obs, e.exp);
            end
        end
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 200 && sb.size() > 0; i++) step();
        tests++;
        assert (sb.size() == 0) else begin
            fails++;
            $error("FAIL %s drain: observed %0d entries left expected 0", tag, sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int e0;
        tests      = 0;
        fails      = 0;
        edge_n     = 0;
        rst_n      = 1'b0;
        io.pulse_f = '0;
        io.ovf_clr = '0;
        #1;
        tests++;
        assert (outs() === 12'h000) else begin
            fails++;
            $error("FAIL reset_state: observed %h expected 000", outs());
        end
        step();
        step();
        rst_n = 1'b1;
        step();

        // single pulse on ch0
        e0 = edge_n + 1;
        push_train("single_ch0", 4'b0001, e0, 1, 1 << 30, 1 << 30);
        io.pulse_f = 4'b0001;
        step();
        io.pulse_f = 4'b0000;
        drain("single_ch0");

        // three consecutive pulses on ch1
        e0 = edge_n + 1;
        push_train("burst3_ch1", 4'b0010, e0, 3, 1 << 30, 1 << 30);
        io.pulse_f = 4'b0010;
        repeat (3) step();
        io.pulse_f = 4'b0000;
        drain("burst3_ch1");

        // five pulses on ch2: saturation and overflow
        e0 = edge_n + 1;
        push_train("sat_ch2", 4'b0100, e0, 4, e0 + 4, 1 << 30);
        io.pulse_f = 4'b0100;
        repeat (5) step();
        io.pulse_f = 4'b0000;
        drain("sat_ch2");
        push(edge_n + 1, 4'b0, 4'b0, 4'b0100, "ovf_hold");
        step();
        io.ovf_clr = 4'b0100;
        push(edge_n + 1, 4'b0, 4'b0, 4'b0000, "ovf_clr");
        step();
        io.ovf_clr = 4'b0000;
        push(edge_n + 1, 4'b0, 4'b0, 4'b0000, "ovf_stays_clr");
        step();

        // simultaneous ch0 and ch3
        e0 = edge_n + 1;
        push_train("simul_ch03", 4'b1001, e0, 1, 1 << 30, 1 << 30);
        io.pulse_f = 4'b1001;
        step();
        io.pulse_f = 4'b0000;
        drain("simul_ch03");

        // pulse exactly at the gap-end cycle on ch3
        e0 = edge_n + 1;
        push_train("gap_end_ch3", 4'b1000, e0, 2, 1 << 30, 1 << 30);
        io.pulse_f = 4'b1000;
        step();
        io.pulse_f = 4'b0000;
        repeat (5) step();
        io.pulse_f = 4'b1000;
        step();
        io.pulse_f = 4'b0000;
        drain("gap_end_ch3");

        // reset mid-stretch with two events pending on ch1
        e0 = edge_n + 1;
        for (int c = 0; c < 3; c++) push(e0 + c, 4'b0010, 4'b0010, 4'b0, "pre_reset");
        io.pulse_f = 4'b0010;
        repeat (3) step();
        io.pulse_f = 4'b0000;
        #1;
        rst_n = 1'b0;
        #1;
        tests++;
        assert (outs() === 12'h000) else begin
            fails++;
            $error("FAIL async_reset: observed %h expected 000", outs());
        end
        step();
        rst_n = 1'b1;
        for (int c = 1; c <= 20; c++) push(edge_n + c, 4'b0, 4'b0, 4'b0, "post_reset_quiet");
        repeat (20) step();
        drain("post_reset_quiet");

        // overflow set and clear in the same cycle on ch2
        e0 = edge_n + 1;
        push_train("set_clr_ch2", 4'b0100, e0, 4, e0 + 4, e0 + 4);
        io.pulse_f = 4'b0100;
        repeat (4) step();
        io.ovf_clr = 4'b0100;
        step();
        io.pulse_f = 4'b0000;
        step();
        io.ovf_clr = 4'b0000;
        drain("set_clr_ch2");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/pulse_stretch_mc.md
Name: pulse_stretch_mc

Overview:
- Multi-channel pulse conditioner in the fast clock domain. It is the source-side front end for fast-to-slow single-bit crossings.
- Each single-cycle pulse on `pulse_f[i]` becomes a level pulse held high for STRETCH fast cycles, then at least GAP low cycles, so a slower domain's 2-flop synchroniser cannot miss it or merge two events.
- Pulses arriving while a channel is busy are queued in a per-channel saturating pending counter. Pulses lost to saturation are flagged as overflow.

Parameters:
- CH, 4, number of independent channels.
- STRETCH, 3, fast cycles each output pulse stays high (≥1; set ≥ ceil(T_slow/T_fast)+1).
- GAP, 3, minimum fast cycles low between consecutive output pulses on a channel (≥1).
- PEND_W, 2, pending-counter width; maximum queued events = 2^PEND_W-1.

Ports:
- clk_f  input  1  fast-domain clock, all logic on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- pulse_f  input  CH  single-cycle event pulses, one bit per channel.
- ovf_clr  input  CH  per-channel clear for the sticky overflow flag.
- level_out  output  CH  stretched pulses, registered, for the slow-domain synchroniser.
- busy  output  CH  channel is stretching, in its gap, or has pending events.
- overflow  output  CH  sticky flag: an event was dropped because pending was saturated.

Behaviour:
- Reset: async on rst_n low. All per-channel state is IDLE, cycle counters are 0, pending is 0, and `level_out`, `busy` and `overflow` are 0. Release is synchronous to `clk_f`.
- Channels are fully independent. Each has a 3-state FSM, a cycle counter of width $clog2(max(STRETCH,GAP)+1), and a PEND_W-bit pending counter.
- IDLE:
  - If `pulse_f[i]` is 1 at edge N, go to HIGH at edge N. `level_out[i]` is 1 from edge N (latency 1 cycle from pulse sample). The counter is loaded.
  - If `pend` > 0 in IDLE, go to HIGH and decrement `pend`. This is unreachable in normal flow and is kept for robustness.
- HIGH:
  - `level_out[i]` = 1 for exactly STRETCH cycles, then go to GAP.
- GAP:
  - `level_out[i]` = 0 for exactly GAP cycles.
  - At the end of GAP, if `pend` > 0 or `pulse_f[i]` = 1, go directly to HIGH (no extra idle cycle) and consume one event. Otherwise go to IDLE.
- Pending accounting:
  - A pulse arriving in HIGH or GAP (and not consumed at GAP end) increments `pend`.
  - If the increment and a GAP-end consume happen in the same cycle, `pend` is unchanged.
  - If `pend` = 2^PEND_W-1 and an increment is required with no consume, `pend` holds and `overflow[i]` sets.
- `overflow[i]` is sticky.
  - `ovf_clr[i]` clears it on the next edge.
  - If a set and a clear coincide, set wins.
- `busy[i]` = (state ≠ IDLE) or (`pend` ≠ 0). It is combinational from registered state, so there are no combinational paths from inputs to outputs.
- `level_out` is driven directly from a flop with no decode glitches, so it is safe to synchronise.
- Minimum output period is STRETCH+GAP cycles. Sustained input rate above 1/(STRETCH+GAP) eventually overflows.
- Reset mid-operation drops all pending events immediately. No output pulses occur after reset release unless new pulses arrive.

Test Plan:
1. Single pulse on ch0 sampled at edge 10:
   - `level_out[0]` = 1 for edges 10–12 and 0 from edge 13.
   - `busy[0]` = 1 for edges 10–15 and 0 at edge 16.
   - Other channels stay 0.
2. Three consecutive-cycle pulses on ch1 starting at edge 20:
   - Three high periods, each 3 cycles, starting at edges 20, 26 and 32 with 3-cycle lows between.
   - `pend` peaks at 2. `overflow` stays 0.
3. Five consecutive pulses on ch2 (PEND_W=2):
   - `pend` saturates at 3 on the 4th pulse. The 5th pulse sets `overflow[2]`.
   - Exactly 4 stretched pulses are output.
   - Then `ovf_clr[2]` = 1 for one cycle drives `overflow[2]` to 0 on the next edge.
4. Simultaneous pulses on ch0 and ch3 at the same edge:
   - `level_out[0]` and `level_out[3]` have identical waveforms. ch1 and ch2 stay 0.
   - Then a pulse on ch3 exactly at its GAP-end cycle gives back-to-back HIGH with no idle cycle, and `pend` is unchanged.
5. Reset mid-stretch: `rst_n` = 0 while ch1 is in HIGH with `pend` = 2:
   - All outputs go to 0 asynchronously.
   - After release with no input, `level_out` and `busy` stay 0 for 20 cycles.
6. Overflow set/clear collision: `ovf_clr[2]` = 1 in the same cycle as a saturating pulse:
   - `overflow[2]` remains 1.
   - Clear alone on the next cycle drives it to 0.
